// File: rtl/flash_pkg.sv
// Shared timing constants and FSM encoding for the LED flash generator/detector pair.
// Both ends import the same defaults so their notion of timing agrees.
package flash_pkg;

  localparam int DEF_TIMEOUT   = 1024;
  localparam int DEF_MIN_PULSE = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HIGH = 2'd1;
  localparam state_t ST_LOW  = 2'd2;

endpackage

// File: rtl/flash_sync_filter.sv
// Two-flop synchronizer plus glitch filter for the observed LED line.
// Emits the filtered level and one-cycle rise/fall strobes aligned with its change.
module flash_sync_filter
  import flash_pkg::*;
#(
  parameter int MIN_PULSE = DEF_MIN_PULSE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ld,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(MIN_PULSE + 1);
  localparam logic [CW-1:0] LAST = CW'(MIN_PULSE - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // r_cnt holds how many consecutive synchronized samples have disagreed with r_level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_ld;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 != r_level) begin
        if (r_cnt == LAST) begin
          r_level <= r_s2;
          r_rise  <= r_s2;
          r_fall  <= ~r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/flash_detect.sv
// Decides whether a sampled LED line is flashing: measures rise-to-rise period,
// counts blinks and flags a steady-on line after TIMEOUT cycles without a rise.
module flash_detect
  import flash_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int BLINK_W   = 8,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int MIN_PULSE = DEF_MIN_PULSE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_in,
  input  logic               clr,
  output logic               flashing,
  output logic               steady_on,
  output logic [BLINK_W-1:0] blink_cnt,
  output logic [CNT_W-1:0]   period,
  output logic               period_vld,
  output logic [1:0]         o_state
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  logic               w_level;
  logic               w_rise;
  logic               w_fall;
  logic               w_timeout;
  state_t             r_state;
  logic [CNT_W-1:0]   r_gap;
  logic [CNT_W-1:0]   r_period;
  logic [BLINK_W-1:0] r_blink;
  logic               r_vld;
  logic               r_flashing;
  logic               r_steady;

  flash_sync_filter #(.MIN_PULSE(MIN_PULSE)) u_filter (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_ld    (ld_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_timeout = (r_gap == TO);

  // Gap saturates at TIMEOUT, so a rise arriving exactly then still measures TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_gap      <= '0;
      r_period   <= '0;
      r_blink    <= '0;
      r_vld      <= 1'b0;
      r_flashing <= 1'b0;
      r_steady   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (w_rise && (r_blink != '1)) r_blink <= r_blink + 1'b1;
      if (w_rise)          r_gap <= CNT_W'(1);
      else if (!w_timeout) r_gap <= r_gap + 1'b1;
      if (w_fall) r_steady <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_rise) r_state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_state <= ST_LOW;
          end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_steady   <= 1'b1;
            r_flashing <= 1'b0;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_period   <= r_gap;
            r_vld      <= 1'b1;
            r_flashing <= 1'b1;
            r_state    <= ST_HIGH;
          end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_steady   <= 1'b0;
            r_flashing <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Clear zeroes the outputs, but a coincident rise still becomes the new reference.
      if (clr) begin
        r_flashing <= 1'b0;
        r_period   <= '0;
        r_vld      <= 1'b0;
        r_steady   <= 1'b0;
        r_blink    <= w_rise ? BLINK_W'(1) : '0;
        r_state    <= w_rise ? ST_HIGH : ST_IDLE;
        r_gap      <= w_rise ? CNT_W'(1) : '0;
      end
    end
  end

  assign flashing   = r_flashing;
  assign steady_on  = r_steady;
  assign blink_cnt  = r_blink;
  assign period     = r_period;
  assign period_vld = r_vld;
  assign o_state    = r_state;

endmodule

// File: tb/tb_flash_detect.sv
// Bench for flash_detect: directed scenarios plus random blink patterns, checked
// every cycle against a time-stamp based reference model of the detector.
module tb_flash_detect;

  localparam int CNT_W     = 16;
  localparam int BLINK_W   = 8;
  localparam int TIMEOUT   = 1024;
  localparam int MIN_PULSE = 2;
  localparam int BLINK_MAX = (1 << BLINK_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ld_in = 1'b0;
  logic clr   = 1'b0;

  logic               flashing;
  logic               steady_on;
  logic [BLINK_W-1:0] blink_cnt;
  logic [CNT_W-1:0]   period;
  logic               period_vld;
  logic [1:0]         state_dbg;

  always #5 clk = ~clk;

  flash_detect #(
    .CNT_W     (CNT_W),
    .BLINK_W   (BLINK_W),
    .TIMEOUT   (TIMEOUT),
    .MIN_PULSE (MIN_PULSE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_in      (ld_in),
    .clr        (clr),
    .flashing   (flashing),
    .steady_on  (steady_on),
    .blink_cnt  (blink_cnt),
    .period     (period),
    .period_vld (period_vld),
    .o_state    (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int vld_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Line history gives the synchronized samples; the measurement side works on
  // absolute edge indices: age = edges since the reference rise was taken.
  logic [CNT_W-1:0] exp_q[$];
  bit m_q[$];
  bit m_lvl, m_pr, m_pf;
  bit m_ref, m_fell;
  int m_edge, m_r;
  bit m_flash, m_steady, m_vld;
  int m_blink, m_period;

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k <= MIN_PULSE; k++) m_q.push_back(1'b0);
    m_lvl = 0; m_pr = 0; m_pf = 0; m_ref = 0; m_fell = 0;
    m_edge = 0; m_r = 0;
    m_flash = 0; m_steady = 0; m_vld = 0; m_blink = 0; m_period = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit rise, fall, all_diff;
    int age;
    m_edge++;
    rise  = m_pr;
    fall  = m_pf;
    age   = m_edge - m_r;
    m_vld = 0;
    if (clr) begin
      m_flash = 0; m_period = 0; m_steady = 0; m_blink = 0; m_ref = 0;
      if (rise) begin
        m_ref = 1; m_fell = 0; m_r = m_edge; m_blink = 1;
      end
    end else begin
      if (rise && m_blink < BLINK_MAX) m_blink++;
      if (fall) m_steady = 0;
      if (!m_ref) begin
        if (rise) begin m_ref = 1; m_fell = 0; m_r = m_edge; end
      end else if (!m_fell) begin
        if (fall) m_fell = 1;
        else if (age >= TIMEOUT) begin m_ref = 0; m_steady = 1; m_flash = 0; end
      end else begin
        if (rise) begin
          m_period = (age < TIMEOUT) ? age : TIMEOUT;
          m_vld = 1;
          exp_q.push_back(CNT_W'(m_period));
          m_flash = 1; m_r = m_edge; m_fell = 0;
        end else if (age >= TIMEOUT) begin
          m_ref = 0; m_steady = 0; m_flash = 0;
        end
      end
    end
    // level flips once the last MIN_PULSE synchronized samples all disagree with it
    all_diff = 1;
    for (int k = 1; k <= MIN_PULSE; k++) if (m_q[k] == m_lvl) all_diff = 0;
    m_pr = all_diff && !m_lvl;
    m_pf = all_diff && m_lvl;
    if (all_diff) m_lvl = !m_lvl;
    m_q.push_front(ld_in);
    void'(m_q.pop_back());
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("flashing",   32'(flashing),   32'(m_flash));
    check("steady_on",  32'(steady_on),  32'(m_steady));
    check("blink_cnt",  32'(blink_cnt),  32'(m_blink));
    check("period",     32'(period),     32'(m_period));
    check("period_vld", 32'(period_vld), 32'(m_vld));
    if (period_vld) begin
      vld_seen++;
      if (exp_q.size() > 0) check("period_sb", 32'(period), 32'(exp_q.pop_front()));
      else                  check("period_sb_unexpected", 32'(period_vld), 32'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input bit v, input int n);
    ld_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic square(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic clr_pulse(input bit v);
    clr = 1'b1;
    hold(v, 1);
    clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flashing"},  32'(flashing),   32'(0));
    check({tag, "_steady"},    32'(steady_on),  32'(0));
    check({tag, "_blink"},     32'(blink_cnt),  32'(0));
    check({tag, "_period"},    32'(period),     32'(0));
    check({tag, "_vld"},       32'(period_vld), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  int v0;
  int len_h, len_l;

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) hold(i[0], 2);
    hold(1'b0, 2);
    rst = 1'b1;
    check_all_zero("reset");

    // first rise after reset: reference only
    hold(1'b0, 5);
    hold(1'b1, 10);
    check("first_rise_blink", 32'(blink_cnt), 32'(1));
    check("first_rise_flashing", 32'(flashing), 32'(0));
    check("first_rise_no_vld", 32'(vld_seen), 32'(0));
    hold(1'b0, 40);

    // 40/40 square wave, 5 periods
    clr_pulse(1'b0);
    v0 = vld_seen;
    square(5, 40, 40);
    check("sq_blink", 32'(blink_cnt), 32'(5));
    check("sq_period", 32'(period), 32'(80));
    check("sq_flashing", 32'(flashing), 32'(1));
    check("sq_vld_count", 32'(vld_seen - v0), 32'(4));

    // 1-cycle glitches are filtered
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 1);
      hold(1'b0, 5);
    end
    check("glitch_blink", 32'(blink_cnt), 32'(5));
    check("glitch_flashing", 32'(flashing), 32'(1));

    // steady high then steady low
    hold(1'b1, 1100);
    check("hold_hi_steady", 32'(steady_on), 32'(1));
    check("hold_hi_flashing", 32'(flashing), 32'(0));
    hold(1'b0, 8);
    check("drop_steady", 32'(steady_on), 32'(0));
    hold(1'b0, 1100);
    check("hold_lo_steady", 32'(steady_on), 32'(0));
    check("hold_lo_flashing", 32'(flashing), 32'(0));

    // clr mid-flashing, then clr coincident with a filtered rise
    square(2, 40, 40);
    hold(1'b1, 20);
    clr_pulse(1'b1);
    hold(1'b1, 19);
    hold(1'b0, 40);
    check("clr_flashing", 32'(flashing), 32'(0));
    check("clr_blink", 32'(blink_cnt), 32'(0));
    check("clr_period", 32'(period), 32'(0));
    hold(1'b1, 4);
    clr_pulse(1'b1);
    hold(1'b1, 35);
    check("clr_rise_blink", 32'(blink_cnt), 32'(1));
    check("clr_rise_flashing", 32'(flashing), 32'(0));
    hold(1'b0, 40);
    hold(1'b1, 10);
    check("after_clr_period", 32'(period), 32'(80));
    check("after_clr_flashing", 32'(flashing), 32'(1));
    check("after_clr_blink", 32'(blink_cnt), 32'(2));

    // rise landing exactly on the timeout measures TIMEOUT
    hold(1'b1, 490);
    hold(1'b0, 524);
    hold(1'b1, 10);
    check("edge_timeout_period", 32'(period), 32'(TIMEOUT));
    check("edge_timeout_flashing", 32'(flashing), 32'(1));

    // async reset mid-period, off the clock edge
    hold(1'b0, 20);
    #3 rst = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    hold(1'b0, 3);
    rst = 1'b1;

    // blink counter saturation
    hold(1'b0, 10);
    square(300, 4, 4);
    hold(1'b0, 10);
    check("sat_blink", 32'(blink_cnt), 32'(BLINK_MAX));
    check("sat_period", 32'(period), 32'(8));
    check("sat_flashing", 32'(flashing), 32'(1));

    // randomized blink patterns with occasional clr and long holds
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(9))
        0:       begin len_h = $urandom_range(1100, 900); len_l = $urandom_range(60, 1); end
        1:       begin len_h = $urandom_range(60, 1);     len_l = $urandom_range(1100, 900); end
        2, 3:    begin len_h = $urandom_range(3, 1);      len_l = $urandom_range(3, 1); end
        default: begin len_h = $urandom_range(60, 1);     len_l = $urandom_range(60, 1); end
      endcase
      if ($urandom_range(7) == 0) begin
        clr_pulse(1'b1);
        if (len_h > 1) hold(1'b1, len_h - 1);
      end else begin
        hold(1'b1, len_h);
      end
      hold(1'b0, len_l);
    end
    hold(1'b0, 20);

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flash_detect.md
Name: flash_detect

Overview:
- Receive-side companion to the LED flash generator: samples a blinking LED line (ld_in) and decides whether it is flashing.
- Measures the blink period in clk cycles, counts blinks and reports a steady-on or steady-off condition after a timeout.
- Sits between an external or looped-back LED line and status/debug logic, so flash behaviour can be checked in hardware.

Parameters:
- CNT_W, 16, width of the period counter and the period output.
- BLINK_W, 8, width of the blink counter.
- TIMEOUT, 1024, cycles without a filtered edge before the line is declared steady (must be less than 2^CNT_W).
- MIN_PULSE, 2, consecutive equal synchronized samples required to accept a new level (glitch filter, at least 1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- ld_in  in  1  asynchronous LED line under observation.
- clr  in  1  synchronous clear of the measurement state.
- flashing  out  1  high while periodic blinking is detected.
- steady_on  out  1  high when the line has been held high for at least TIMEOUT cycles.
- blink_cnt  out  BLINK_W  accepted rising edges since reset/clr; saturates at all-ones.
- period  out  CNT_W  last measured rising-to-rising interval in cycles.
- period_vld  out  1  one-cycle strobe when period updates.

Behaviour:
- Reset (rst=0, async): all outputs 0, filtered level 0, counters 0, FSM IDLE. Applies immediately, including mid-measurement.
- Synchronizer: 2-flop chain on ld_in. Glitch filter: the filtered level changes only after MIN_PULSE consecutive synchronized samples differ from it.
- Latency: ld_in edge to filtered edge is 2+MIN_PULSE cycles (4 at defaults). period_vld asserts on the cycle after the filtered rising edge.
- gap counter: counts cycles since the last filtered rising edge, saturating at TIMEOUT.
- FSM states:
  - IDLE: no valid reference edge. A filtered rise sets the reference and moves to HIGH. No period is output.
  - HIGH: on a filtered fall go to LOW. On gap reaching TIMEOUT go to IDLE and set steady_on=1.
  - LOW: on a filtered rise do the following:
    - period <= gap.
    - pulse period_vld.
    - flashing <= 1.
    - restart gap at 1.
    - go to HIGH.
  - LOW on gap reaching TIMEOUT: go to IDLE, steady_on=0.
- blink_cnt increments on every filtered rise, in any state, and saturates at 2^BLINK_W-1.
- Timeout: flashing <= 0 in the same cycle the FSM enters IDLE. period and blink_cnt hold their values.
- steady_on clears on the first filtered fall after it was set.
- clr=1:
  - flashing, period, period_vld, blink_cnt and steady_on go to 0.
  - FSM goes to IDLE and gap goes to 0.
  - The synchronizer and filtered level are not touched.
  - If clr coincides with a filtered rise, clr wins for outputs, but the rise is taken as the new reference: FSM goes to HIGH and blink_cnt=1.
- A filtered rise and the timeout in the same cycle: the rise wins and it is measured as period=TIMEOUT.
- period is always at least 2*MIN_PULSE because of the filter.

Decomposition:
- Shared package flash_pkg holds:
  - FSM state typedef (IDLE, HIGH, LOW).
  - default TIMEOUT and MIN_PULSE constants, shared with the flash generator so both ends agree on timing.
- One natural sub-module, flash_sync_filter: 2-flop synchronizer plus MIN_PULSE glitch filter. Outputs are the filtered level plus one-cycle rise and fall strobes. The FSM, counters and outputs stay in flash_detect.

Test Plan:
- Reset: hold rst=0 while toggling ld_in, release -> all outputs 0; first rise after release gives blink_cnt=1, flashing=0, no period_vld.
- Square wave, 40 cycles high / 40 low, 5 periods -> period=80 with period_vld once per rise, flashing=1 from the 2nd rise, blink_cnt=5.
- Glitch: 1-cycle high pulses on ld_in with MIN_PULSE=2 -> no filtered edge, blink_cnt unchanged, outputs stable.
- Hold high 1100 cycles after flashing -> flashing drops to 0 and steady_on goes to 1 at gap=1024. Later drop ld_in -> steady_on=0 after 4 cycles; further low time gives steady_on=0 and flashing=0.
- clr pulse mid-flashing, then clr coincident with a filtered rise -> outputs zeroed; next rise 80 cycles later gives period=80, flashing=1, blink_cnt=2.
- Async reset asserted mid-period with rst not aligned to clk -> outputs 0 immediately. 300 rises without clr or timeout -> blink_cnt saturates at 255.
